// File: rtl/expr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : expr_pkg
// Brief    : Shared encodings and character helpers for the expression stream.
// Revision : 1.0
// ============================================================================
package expr_pkg;

   typedef enum logic [1:0] {
      RS_OTHER = 2'd0,
      RS_INIT  = 2'd1,
      RS_NUM   = 2'd2,
      RS_OP    = 2'd3
   } recog_state_t;

   typedef enum logic [1:0] {
      CS_IDLE   = 2'd0,
      CS_BUSY   = 2'd1,
      CS_REPORT = 2'd2
   } ctrl_state_t;

   localparam logic [7:0] C_DIGIT_LO = 8'h30;
   localparam logic [7:0] C_DIGIT_HI = 8'h39;
   localparam logic [7:0] C_PLUS     = 8'h2B;
   localparam logic [7:0] C_STAR     = 8'h2A;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= C_DIGIT_LO) && (c <= C_DIGIT_HI);
   endfunction

   function automatic logic is_op(input logic [7:0] c);
      return (c == C_PLUS) || (c == C_STAR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/expr_recog.sv
`default_nettype none
// ============================================================================
// Module   : expr_recog
// Brief    : Four-state recognizer for digit (op digit)* expressions.
// Revision : 1.0
// ============================================================================
module expr_recog (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       init,
   input  logic       en,
   input  logic [7:0] in,
   output logic [1:0] state
);
   import expr_pkg::*;

   recog_state_t r_state;
   recog_state_t w_next;

   always_comb begin
      w_next = r_state;
      if (init) begin
         w_next = RS_INIT;
      end else if (en) begin
         case (r_state)
            RS_INIT, RS_OP: w_next = is_digit(in) ? RS_NUM : RS_OTHER;
            RS_NUM:         w_next = is_op(in) ? RS_OP : RS_OTHER;
            default:        w_next = RS_OTHER;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) r_state <= RS_INIT;
      else        r_state <= w_next;
   end

   assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/expr_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : expr_stream_ctrl
// Brief    : Round-robin arbiter sequencing framed character streams through
//            the expression recognizer and reporting one result per frame.
// Revision : 1.0
// ============================================================================
module expr_stream_ctrl #(
   parameter int         N_SRC = 2,
   parameter logic [7:0] TERM  = 8'h3D,
   parameter int         LEN_W = 8
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic [N_SRC-1:0]     src_valid,
   input  logic [8*N_SRC-1:0]   src_data,
   output logic [N_SRC-1:0]     src_ready,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 res_accept,
   output logic [1:0]           res_src,
   output logic [LEN_W-1:0]     res_len
);
   import expr_pkg::*;

   localparam logic [1:0] C_LAST = 2'(N_SRC - 1);

   ctrl_state_t      r_state;
   ctrl_state_t      w_next;
   logic [1:0]       r_grant;
   logic [1:0]       r_rr_ptr;
   logic [LEN_W-1:0] r_len;
   logic             r_res_accept;
   logic [1:0]       r_res_src;
   logic [LEN_W-1:0] r_res_len;

   logic [3:0]  w_valid_pad;
   logic [3:0]  w_ready_pad;
   logic [31:0] w_data_pad;
   logic [7:0]  w_char;
   logic [1:0]  w_pick;
   logic [1:0]  w_idx;
   logic [1:0]  w_rstate;
   logic        w_any;
   logic        w_xfer;
   logic        w_is_term;
   logic        w_start;
   logic        w_step;

   function automatic logic [1:0] wrap_inc(input logic [1:0] v);
      return (v == C_LAST) ? 2'd0 : v + 2'd1;
   endfunction

   // Pad to four sources so indexing by the 2-bit grant is always in range.
   always_comb begin
      w_valid_pad                 = '0;
      w_valid_pad[N_SRC-1:0]      = src_valid;
      w_data_pad                  = '0;
      w_data_pad[8*N_SRC-1:0]     = src_data;
   end

   always_comb begin
      w_any  = 1'b0;
      w_pick = r_rr_ptr;
      w_idx  = r_rr_ptr;
      for (int k = 0; k < N_SRC; k++) begin
         if (!w_any && w_valid_pad[w_idx]) begin
            w_any  = 1'b1;
            w_pick = w_idx;
         end
         w_idx = wrap_inc(w_idx);
      end
   end

   assign w_char      = w_data_pad[{r_grant, 3'b000} +: 8];
   assign w_xfer      = (r_state == CS_BUSY) && w_valid_pad[r_grant];
   assign w_is_term   = (w_char == TERM);
   assign w_start     = (r_state == CS_IDLE) && w_any;
   assign w_step      = w_xfer && !w_is_term;
   assign w_ready_pad = 4'b0001 << r_grant;

   assign src_ready  = (r_state == CS_BUSY) ? w_ready_pad[N_SRC-1:0] : '0;
   assign res_valid  = (r_state == CS_REPORT);
   assign res_accept = r_res_accept;
   assign res_src    = r_res_src;
   assign res_len    = r_res_len;

   always_comb begin
      w_next = r_state;
      case (r_state)
         CS_IDLE:   if (w_any)                w_next = CS_BUSY;
         CS_BUSY:   if (w_xfer && w_is_term)  w_next = CS_REPORT;
         CS_REPORT: if (res_ready)            w_next = CS_IDLE;
         default:                             w_next = CS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) r_state <= CS_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_grant      <= '0;
         r_rr_ptr     <= '0;
         r_len        <= '0;
         r_res_accept <= 1'b0;
         r_res_src    <= '0;
         r_res_len    <= '0;
      end else begin
         if (w_start) begin
            r_grant <= w_pick;
            r_len   <= '0;
         end
         if (w_step && (r_len != {LEN_W{1'b1}})) r_len <= r_len + 1'b1;
         if (w_xfer && w_is_term) begin
            r_res_accept <= (recog_state_t'(w_rstate) == RS_NUM);
            r_res_src    <= r_grant;
            r_res_len    <= r_len;
         end
         if ((r_state == CS_REPORT) && res_ready) r_rr_ptr <= wrap_inc(r_grant);
      end
   end

   expr_recog u_recog (
      .clk   (clk),
      .clr_n (clr_n),
      .init  (w_start),
      .en    (w_step),
      .in    (w_char),
      .state (w_rstate)
   );

endmodule
`default_nettype wire

// File: tb/tb_expr_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_expr_stream_ctrl
// Brief    : Self-checking bench: frame tables, directed corners, random traffic.
// Revision : 1.0
// ============================================================================
module tb_expr_stream_ctrl;

   localparam int         N    = 2;
   localparam logic [7:0] TERM = 8'h3D;

   logic           clk = 1'b0;
   logic           clr_n;
   logic [N-1:0]   src_valid;
   logic [8*N-1:0] src_data;
   logic [N-1:0]   src_ready;
   logic           res_valid;
   logic           res_ready;
   logic           res_accept;
   logic [1:0]     res_src;
   logic [7:0]     res_len;

   always #5 clk = ~clk;

   expr_stream_ctrl #(.N_SRC(N), .TERM(TERM), .LEN_W(8)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .src_valid  (src_valid),
      .src_data   (src_data),
      .src_ready  (src_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_accept (res_accept),
      .res_src    (res_src),
      .res_len    (res_len)
   );

   typedef struct packed { logic acc; logic [7:0] len; } res_t;
   typedef struct { int src; string frame; logic acc; int len; } vec_t;

   byte unsigned cq[N][$];
   res_t         eq[N][$];
   int           seen[$];
   int           n_err = 0;
   int           n_chk = 0;

   logic         clr_drive = 1'b0;
   logic         rr_drive  = 1'b1;
   logic         rr_rand   = 1'b0;
   logic         stall_rand = 1'b0;
   logic [N-1:0] stall = '0;

   // Reference: which phase the block is in, whom it serves, what it reports.
   logic       m_busy, m_report, m_acc;
   logic [1:0] m_grant, m_src;
   int         m_ptr;
   logic [7:0] m_len;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic res_t ref_eval(string b);
      res_t r;
      int   n = b.len();
      logic ok = (n % 2 == 1);
      for (int i = 0; i < n; i++) begin
         byte unsigned c = b[i];
         if (i % 2 == 0) ok = ok && (c >= 8'h30) && (c <= 8'h39);
         else            ok = ok && ((c == 8'h2B) || (c == 8'h2A));
      end
      r.acc = ok;
      r.len = (n > 255) ? 8'd255 : 8'(n);
      return r;
   endfunction

   function automatic logic all_idle();
      logic e = !m_busy && !m_report;
      for (int i = 0; i < N; i++) e = e && (cq[i].size() == 0) && (eq[i].size() == 0);
      return e;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_report = 1'b0; m_acc = 1'b0;
      m_grant = '0; m_src = '0; m_ptr = 0; m_len = '0;
   endtask

   task automatic enq(int s, string f, logic acc, int len);
      for (int i = 0; i < f.len(); i++) cq[s].push_back(f[i]);
      eq[s].push_back('{acc, 8'(len)});
   endtask

   task automatic cycle();
      logic [N-1:0] exp_ready;
      logic         v, found;
      byte unsigned c;
      res_t         r;
      int           g, idx;
      @(negedge clk);
      for (int i = 0; i < N; i++) exp_ready[i] = m_busy && (m_grant == 2'(i));
      chk("src_ready", 32'(src_ready), 32'(exp_ready));
      chk("res_valid", 32'(res_valid), 32'(m_report));
      chk("res_accept", 32'(res_accept), 32'(m_acc));
      chk("res_src", 32'(res_src), 32'(m_src));
      chk("res_len", 32'(res_len), 32'(m_len));

      clr_n     = clr_drive;
      res_ready = rr_rand ? 1'($urandom_range(1)) : rr_drive;
      for (int i = 0; i < N; i++) begin
         v = (cq[i].size() > 0) && !stall[i] && !(stall_rand && ($urandom_range(3) == 0));
         src_valid[i]      = v;
         src_data[8*i +: 8] = v ? cq[i][0] : 8'($urandom);
      end

      if (!clr_drive) begin
         model_reset();
      end else if (m_report) begin
         if (res_ready) begin
            seen.push_back(int'(res_src));
            m_report = 1'b0;
            m_ptr    = (int'(m_grant) + 1) % N;
         end
      end else if (m_busy) begin
         g = int'(m_grant);
         if (src_valid[g]) begin
            c = cq[g].pop_front();
            if (c == TERM) begin
               r        = eq[g].pop_front();
               m_acc    = r.acc;
               m_len    = r.len;
               m_src    = m_grant;
               m_busy   = 1'b0;
               m_report = 1'b1;
            end
         end
      end else begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && src_valid[idx]) begin
               found   = 1'b1;
               m_grant = 2'(idx);
            end
         end
         if (found) m_busy = 1'b1;
      end
   endtask

   task automatic drain(string name, int budget);
      int c = 0;
      while (c < budget && !all_idle()) begin
         cycle();
         c++;
      end
      n_chk++;
      if (!all_idle()) begin
         n_err++;
         $display("FAIL drain_%s: pending frames remain after %0d cycles, required none", name, budget);
      end
   endtask

   task automatic wait_q(int s, int sz, int budget);
      int c = 0;
      while (c < budget && cq[s].size() > sz) begin
         cycle();
         c++;
      end
      chk("wait_queue", 32'(cq[s].size()), 32'(sz));
   endtask

   task automatic wait_report(int budget);
      int c = 0;
      while (c < budget && !m_report) begin
         cycle();
         c++;
      end
      chk("wait_report", 32'(m_report), 32'd1);
   endtask

   vec_t  tbl[9];
   string s;
   string body;
   res_t  rr;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      clr_n = 1'b0; res_ready = 1'b1; src_valid = '0; src_data = '0;

      // Both sources hold frames through reset; grants must alternate.
      for (int r = 0; r < 4; r++) begin
         enq(0, "7=", 1'b1, 1);
         enq(1, "7=", 1'b1, 1);
      end
      cycle(); cycle();
      clr_drive = 1'b1;
      seen.delete();
      drain("alternate", 200);
      chk("alt_count", 32'(seen.size()), 32'd8);
      foreach (seen[k]) chk("alt_src", 32'(seen[k]), 32'(k % 2));

      tbl[0] = '{0, "1+2*3=", 1'b1, 5};
      tbl[1] = '{1, "12=",    1'b0, 2};
      tbl[2] = '{1, "3+=",    1'b0, 2};
      tbl[3] = '{0, "=",      1'b0, 0};
      tbl[4] = '{0, "9=",     1'b1, 1};
      tbl[5] = '{1, "4*5+6=", 1'b1, 5};
      tbl[6] = '{0, "+1=",    1'b0, 2};
      tbl[7] = '{1, "a=",     1'b0, 1};
      tbl[8] = '{0, "7*=",    1'b0, 2};
      foreach (tbl[i]) begin
         enq(tbl[i].src, tbl[i].frame, tbl[i].acc, tbl[i].len);
         drain("table", 60);
      end

      // Granted source stalls mid-frame while the other one waits.
      enq(0, "1+2=", 1'b1, 3);
      wait_q(0, 2, 20);
      enq(1, "5=", 1'b1, 1);
      stall[0] = 1'b1;
      repeat (4) cycle();
      stall[0] = 1'b0;
      drain("stall", 60);

      // Result back-pressure.
      rr_drive = 1'b0;
      enq(1, "8=", 1'b1, 1);
      enq(0, "2*3=", 1'b1, 3);
      wait_report(40);
      repeat (5) cycle();
      rr_drive = 1'b1;
      drain("backpressure", 60);

      // Length saturation.
      s = "";
      for (int i = 0; i < 150; i++) s = {s, "1+"};
      s = {s, "1="};
      enq(0, s, 1'b1, 255);
      drain("saturate", 700);

      // Reset in the middle of a frame drops it.
      enq(1, "4+5=", 1'b1, 3);
      wait_q(1, 2, 30);
      cq[1].delete(); eq[1].delete();
      clr_drive = 1'b0;
      cycle();
      clr_drive = 1'b1;
      cycle();
      enq(0, "5=", 1'b1, 1);
      drain("after_reset", 60);

      // Random traffic with stalls and random result back-pressure.
      stall_rand = 1'b1;
      rr_rand    = 1'b1;
      for (int f = 0; f < 40; f++) begin
         body = "";
         for (int i = 0; i < int'($urandom_range(0, 9)); i++) begin
            byte unsigned c;
            if (i % 2 == 0) c = 8'(8'h30 + $urandom_range(9));
            else            c = ($urandom_range(1) == 1) ? 8'h2B : 8'h2A;
            if ($urandom_range(5) == 0) begin
               case ($urandom_range(3))
                  0: c = 8'h61;
                  1: c = 8'h2B;
                  2: c = 8'h35;
                  default: c = 8'h20;
               endcase
            end
            body = $sformatf("%s%c", body, c);
         end
         rr = ref_eval(body);
         enq(int'($urandom_range(N - 1)), {body, "="}, rr.acc, int'(rr.len));
         repeat ($urandom_range(1, 6)) cycle();
      end
      drain("random", 3000);
      stall_rand = 1'b0;
      rr_rand    = 1'b0;
      rr_drive   = 1'b1;
      cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
